bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 85 ++++++++
 tb/tb_bit_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end, shifts a WIDTH-bit word out MSB first on a line that idles high.
// Latency: a load accepted at edge k puts the MSB on out in cycle k+1; a frame is WIDTH consecutive valid cycles.
// Backpressure: ready is low for WIDTH-1 cycles per frame; a load taken during the last bit streams with no gap.
//
// Ports:
//   clk    - single clock, all state changes on posedge
//   reset  - synchronous active-high reset, dominates every other input
//   data   - parallel word, sampled only on an accepted load
//   load   - load request, accepted when load && ready at a clock edge
//   out    - serial bit, MSB first; 1 when not shifting
//   valid  - out carries a data bit
//   ready  - a load presented now is accepted on the coming edge
//   last   - out carries bit 0 (LSB) of the current word
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             out,
  output logic             valid,
  output logic             ready,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             accept;

  // Every output is a decode of registered state only, so load/data
  // never reach an output combinationally.
  assign valid  = (state == SHIFT);
  assign last   = (state == SHIFT) && (cnt == LAST_CNT);
  assign ready  = (state == IDLE) || last;
  assign out    = (state == SHIFT) ? shreg[WIDTH-1] : 1'b1;
  assign accept = load && ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (accept) begin
      // Covers both a load from IDLE and the gap-free reload on the last bit.
      shreg_nxt = data;
      cnt_nxt   = '0;
      state_nxt = SHIFT;
    end else if (state == SHIFT) begin
      if (last) begin
        // Frame done with no reload: drop back to idle, clear the stale word.
        state_nxt = IDLE;
        cnt_nxt   = '0;
        shreg_nxt = '0;
      end else begin
        shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        cnt_nxt   = cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] data;
  logic       load;
  logic       out;
  logic       valid;
  logic       ready;
  logic       last;

  logic       reset2;
  logic [1:0] data2;
  logic       load2;
  logic       out2;
  logic       valid2;
  logic       ready2;
  logic       last2;

  int checks;
  int errors;

  bit_serializer #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .load  (load),
    .out   (out),
    .valid (valid),
    .ready (ready),
    .last  (last)
  );

  bit_serializer #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (reset2),
    .data  (data2),
    .load  (load2),
    .out   (out2),
    .valid (valid2),
    .ready (ready2),
    .last  (last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] d;
    logic       o;
    logic       v;
    logic       r;
    logic       l;
    int         grp;
  } vec_t;

  vec_t vecs[$];
  int   grp;

  task automatic add(input logic rst, input logic ld, input logic [7:0] d,
                     input logic o, input logic v, input logic r, input logic l);
    vec_t x;
    x.rst = rst; x.ld = ld; x.d = d;
    x.o = o; x.v = v; x.r = r; x.l = l;
    x.grp = grp;
    vecs.push_back(x);
  endtask

  // One 8-bit frame: load d at position 0, optionally keep load high with
  // hold_d for positions 1..hold_end; exp is the hand-written MSB-first bit pattern.
  task automatic add_frame(input logic [7:0] d, input int hold_end,
                           input logic [7:0] hold_d, input logic [7:0] exp);
    for (int i = 0; i < 8; i++) begin
      logic ld;
      logic [7:0] dd;
      ld = (i == 0) || (i >= 1 && i <= hold_end);
      dd = (i == 0) ? d : hold_d;
      add(1'b0, ld, dd, exp[7-i], 1'b1, (i == 7), (i == 7));
    end
  endtask

  task automatic check2(input string nm, input logic o, input logic v,
                        input logic r, input logic l);
    checks++;
    if ({out2, valid2, ready2, last2} !== {o, v, r, l}) begin
      errors++;
      $display("FAIL %s: out/valid/ready/last got %b%b%b%b want %b%b%b%b",
               nm, out2, valid2, ready2, last2, o, v, r, l);
    end
  endtask

  logic [15:0] pat;
  int          zc;
  int          pulses[$];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0; load  = 1'b0; data  = '0;
    reset2 = 1'b1; load2 = 1'b0; data2 = '0;

    // group 1: reset, single frame 0010_1101, return to idle
    grp = 1;
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    add_frame(8'h2D, 0, 8'h00, 8'b0010_1101);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    // group 2: A5 then F0 back-to-back, load held through the last bit
    grp = 2;
    add_frame(8'hA5, 7, 8'hF0, 8'b1010_0101);
    add_frame(8'hF0, 0, 8'h00, 8'b1111_0000);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    // group 3: load of FF ignored during cycles 2..6 of an all-zero frame
    grp = 3;
    add_frame(8'h00, 5, 8'hFF, 8'b0000_0000);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    // group 4: reset during the 4th bit, then reset+load collision
    grp = 4;
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      load  = vecs[i].ld;
      data  = vecs[i].d;
      @(posedge clk);
      #1;
      checks++;
      if ({out, valid, ready, last} !== {vecs[i].o, vecs[i].v, vecs[i].r, vecs[i].l}) begin
        errors++;
        $display("FAIL vec[%0d] grp %0d: out/valid/ready/last got %b%b%b%b want %b%b%b%b",
                 i, vecs[i].grp, out, valid, ready, last,
                 vecs[i].o, vecs[i].v, vecs[i].r, vecs[i].l);
      end
    end

    // WIDTH=2: 01, then 10 reloaded on the last bit
    reset = 1'b0; load = 1'b0; data = '0;
    reset2 = 1'b1; @(posedge clk); #1;
    check2("w2_reset", 1'b1, 1'b0, 1'b1, 1'b0);
    reset2 = 1'b0; load2 = 1'b1; data2 = 2'b01; @(posedge clk); #1;
    check2("w2_bit0", 1'b0, 1'b1, 1'b0, 1'b0);
    load2 = 1'b1; data2 = 2'b10; @(posedge clk); #1;
    check2("w2_bit1", 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check2("w2_b2b_bit0", 1'b1, 1'b1, 1'b0, 1'b0);
    load2 = 1'b0; data2 = 2'b00; @(posedge clk); #1;
    check2("w2_b2b_bit1", 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check2("w2_idle", 1'b1, 1'b0, 1'b1, 1'b0);

    // downstream zero detector: pulse on every third zero seen on the line
    pat = 16'b0010_0101_1011_1010;
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0;
    zc = 0;
    for (int s = 0; s < 24; s++) begin
      int f;
      f = s - 4;
      load = (s >= 4 && s <= 12);
      data = (s == 4) ? 8'h25 : 8'hBA;
      @(posedge clk);
      #1;
      if (out == 1'b0) begin
        zc++;
        if (zc == 3) begin
          zc = 0;
          pulses.push_back(s - 3);
        end
      end
      if (f >= 0 && f < 16) begin
        checks++;
        if (out !== pat[15-f] || valid !== 1'b1) begin
          errors++;
          $display("FAIL stream bit %0d: out=%b valid=%b want out=%b valid=1",
                   f, out, valid, pat[15-f]);
        end
      end
    end
    load = 1'b0;
    checks++;
    if (pulses.size() != 2) begin
      errors++;
      $display("FAIL det_pulse_count: got %0d want 2", pulses.size());
    end else begin
      checks++;
      if (pulses[0] != 4 || pulses[1] != 10) begin
        errors++;
        $display("FAIL det_pulse_pos: got %0d,%0d want 4,10", pulses[0], pulses[1]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
